// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI configuration register front end:
// register map, frame layout and the receive FSM state encoding.
package spi_cfg_pkg;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    // One past a full frame, so an oversized frame is distinguishable from 16
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = FRAME_BITS + 1;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/spi_cfg_regs_if.sv
// SPI host-to-slave pin bundle (mode 0, write-only: no CIPO).
interface spi_cfg_regs_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_cfg_regs_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with rise/fall detection
// derived from flops only (no combinational path from the raw pin).
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              q_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            q_d  <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_cfg_regs.sv
// SPI-slave write decoder: captures 16-bit frames and commits the data byte
// to one of the PWM control registers when the frame is a valid write.
module spi_cfg_regs
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_cfg_regs_if.slave        spi,
    output logic [7:0]           en_reg_out_7_0,
    output logic [7:0]           en_reg_out_15_8,
    output logic [7:0]           en_reg_pwm_7_0,
    output logic [7:0]           en_reg_pwm_15_8,
    output logic [7:0]           pwm_duty_cycle,
    output logic                 cfg_wr,
    output logic [6:0]           cfg_addr
);

    logic sclk_q, sclk_rise, sclk_fall;
    logic copi_q, copi_rise, copi_fall;
    logic ncs_q, ncs_rise, ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .din(spi.sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .din(spi.copi), .q(copi_q), .rise(copi_rise), .fall(copi_fall)
    );
    // ncs resets to "busy" so a frame in flight at reset release is never seen as starting
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ncs (
        .clk(clk), .rst(rst), .din(spi.ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_q, sclk_fall, copi_rise, copi_fall};

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CNT_W-1:0]        cnt;
    logic [7:0]              regs [NUM_REGS];

    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic       commit;

    assign frame_addr = shreg[ADDR_MSB:ADDR_LSB];
    assign frame_data = shreg[DATA_MSB:DATA_LSB];
    assign commit     = (cnt == CNT_W'(FRAME_BITS)) && shreg[RW_BIT]
                        && (frame_addr < 7'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            cfg_wr   <= 1'b0;
            cfg_addr <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            cfg_wr <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    if (ncs_q) state <= IDLE;
                end
                IDLE: begin
                    if (ncs_fall) begin
                        state <= ACTIVE;
                        shreg <= '0;
                        cnt   <= '0;
                    end
                end
                ACTIVE: begin
                    // ncs rise takes priority over a coincident sclk rise
                    if (ncs_rise) begin
                        state <= IDLE;
                        if (commit) begin
                            for (int i = 0; i < NUM_REGS; i++)
                                if (frame_addr == 7'(i)) regs[i] <= frame_data;
                            cfg_addr <= frame_addr;
                            cfg_wr   <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shreg <= {shreg[FRAME_BITS-2:0], copi_q};
                        if (cnt != CNT_W'(CNT_MAX)) cnt <= cnt + 1'b1;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs[ADDR_DUTY];

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Directed bench for spi_cfg_regs: drives SPI frames bit by bit and checks
// register contents, commit timing and cfg_wr pulse counts.
module tb_spi_cfg_regs;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       cfg_wr;
    logic [6:0] cfg_addr;

    int passed = 0;
    int total  = 0;
    int wr_count = 0;
    int wr_base;
    logic [7:0] exp_regs [5];

    spi_cfg_regs_if spi ();

    spi_cfg_regs #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi(spi),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cfg_wr === 1'b1) wr_count <= wr_count + 1;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_r0"}, 32'(en_reg_out_7_0),  32'(exp_regs[0]));
        check({tag, "_r1"}, 32'(en_reg_out_15_8), 32'(exp_regs[1]));
        check({tag, "_r2"}, 32'(en_reg_pwm_7_0),  32'(exp_regs[2]));
        check({tag, "_r3"}, 32'(en_reg_pwm_15_8), 32'(exp_regs[3]));
        check({tag, "_r4"}, 32'(pwm_duty_cycle),  32'(exp_regs[4]));
    endtask

    // Sends n bits MSB-first starting at frame bit index 'first'; indices past 15 send 0
    task automatic send_bits(input logic [15:0] f, input int first, input int n, input int half);
        for (int i = first; i < first + n; i++) begin
            spi.copi = (i < 16) ? f[15 - i] : 1'b0;
            wait_clks(half);
            spi.sclk = 1'b1;
            wait_clks(half);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] f, input int nbits, input int half);
        spi.ncs = 1'b0;
        wait_clks(half);
        send_bits(f, 0, nbits, half);
        wait_clks(half);
        spi.ncs = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        wait_clks(3);
        check_regs("reset");
        check("reset_cfg_wr", 32'(cfg_wr), 32'h0);
        check("reset_cfg_addr", 32'(cfg_addr), 32'h0);
        rst = 1'b0;
        wait_clks(5);

        // Single write with exact commit timing
        wr_base = wr_count;
        send_frame(16'h8480, 16, 4);
        wait_clks(2);
        check("t1_before", 32'(pwm_duty_cycle), 32'h00);
        wait_clks(1);
        check("t1_duty", 32'(pwm_duty_cycle), 32'h80);
        check("t1_wr_hi", 32'(cfg_wr), 32'h1);
        check("t1_addr", 32'(cfg_addr), 32'h04);
        wait_clks(1);
        check("t1_wr_lo", 32'(cfg_wr), 32'h0);
        exp_regs[4] = 8'h80;
        check_regs("t1");
        check("t1_pulses", 32'(wr_count - wr_base), 32'd1);
        wait_clks(3);

        // Back-to-back writes to all registers
        wr_base = wr_count;
        send_frame(16'h80FF, 16, 3); wait_clks(3);
        send_frame(16'h8155, 16, 3); wait_clks(3);
        send_frame(16'h82AA, 16, 3); wait_clks(3);
        send_frame(16'h8301, 16, 3); wait_clks(3);
        send_frame(16'h8440, 16, 3); wait_clks(6);
        exp_regs[0] = 8'hFF; exp_regs[1] = 8'h55; exp_regs[2] = 8'hAA;
        exp_regs[3] = 8'h01; exp_regs[4] = 8'h40;
        check_regs("b2b");
        check("b2b_pulses", 32'(wr_count - wr_base), 32'd5);
        check("b2b_addr", 32'(cfg_addr), 32'h04);

        // Read frame and out-of-range address are discarded
        wr_base = wr_count;
        send_frame(16'h0012, 16, 4); wait_clks(6);
        send_frame(16'h8533, 16, 4); wait_clks(6);
        check_regs("rd_oor");
        check("rd_oor_pulses", 32'(wr_count - wr_base), 32'd0);
        check("rd_oor_addr", 32'(cfg_addr), 32'h04);

        // Short and oversized frames rejected, then a valid write commits
        wr_base = wr_count;
        send_frame(16'h80FE, 15, 4); wait_clks(6);
        send_frame(16'h80FE, 17, 4); wait_clks(6);
        check_regs("len");
        check("len_pulses", 32'(wr_count - wr_base), 32'd0);
        send_frame(16'h8012, 16, 4); wait_clks(6);
        exp_regs[0] = 8'h12;
        check_regs("len_ok");
        check("len_ok_pulses", 32'(wr_count - wr_base), 32'd1);
        check("len_ok_addr", 32'(cfg_addr), 32'h00);

        // Reset mid-frame discards the partial frame
        spi.ncs = 1'b0;
        wait_clks(4);
        send_bits(16'h8177, 0, 8, 4);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        wr_base = wr_count;
        send_bits(16'h8177, 8, 8, 4);
        wait_clks(4);
        spi.ncs = 1'b1;
        wait_clks(6);
        for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
        check_regs("midrst");
        check("midrst_pulses", 32'(wr_count - wr_base), 32'd0);
        check("midrst_addr", 32'(cfg_addr), 32'h00);
        send_frame(16'h8177, 16, 4); wait_clks(6);
        exp_regs[1] = 8'h77;
        check_regs("midrst_next");
        check("midrst_next_addr", 32'(cfg_addr), 32'h01);

        // Minimum-timing host with random writes against a scoreboard
        begin
            int a, d, last_a;
            last_a = 0;
            wr_base = wr_count;
            for (int n = 0; n < 20; n++) begin
                a = $urandom_range(0, 4);
                d = $urandom_range(0, 255);
                send_frame({1'b1, 7'(a), 8'(d)}, 16, 3);
                wait_clks(3);
                exp_regs[a] = 8'(d);
                last_a = a;
            end
            wait_clks(6);
            check_regs("rand");
            check("rand_pulses", 32'(wr_count - wr_base), 32'd20);
            check("rand_addr", 32'(cfg_addr), 32'(last_a));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
